// File: rtl/light_sample_filter.sv
// light_sample_filter
// Block-averages 8-bit light samples from the SPI sensor reader, tracks the
// peak average, flags a stale sensor after a long silence and drives two
// active-low hex digits (Segment1 = high nibble, Segment2 = low nibble).
// Optional build macro: LIGHT_FILTER_PEAK_HOLD_EN -- when defined the digits
// show the peak average instead of the latest average.
module light_sample_filter #(
  parameter int SAMPLES_LOG2   = 3,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [7:0] i_Sample,
  input  logic       i_Sample_DV,
  input  logic       i_Clear,
  output logic [7:0] o_Avg,
  output logic       o_Avg_DV,
  output logic [7:0] o_Peak,
  output logic       o_Stale,
  output logic       o_Segment1_A,
  output logic       o_Segment1_B,
  output logic       o_Segment1_C,
  output logic       o_Segment1_D,
  output logic       o_Segment1_E,
  output logic       o_Segment1_F,
  output logic       o_Segment1_G,
  output logic       o_Segment2_A,
  output logic       o_Segment2_B,
  output logic       o_Segment2_C,
  output logic       o_Segment2_D,
  output logic       o_Segment2_E,
  output logic       o_Segment2_F,
  output logic       o_Segment2_G
);

  // Accumulator is wide enough for 2^SAMPLES_LOG2 full-scale samples.
  localparam int ACC_W  = 8 + SAMPLES_LOG2;
  localparam int CNT_W  = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'((1 << SAMPLES_LOG2) - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  // Active-low {G,F,E,D,C,B,A}: only the middle bar lit.
  localparam logic [6:0] DASH_N = 7'b0111111;

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic [ACC_W-1:0]  sum;
  logic [7:0]        avg_next;
  logic              accept;
  logic              block_done;
  logic [IDLE_W-1:0] idle;
  logic [7:0]        display_value;
  logic [6:0]        seg1_n;
  logic [6:0]        seg2_n;

  // Active-high {g,f,e,d,c,b,a} pattern for a hex digit.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    case (nibble)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // A strobe that coincides with a clear is thrown away.
  assign accept     = i_Sample_DV && !i_Clear;
  assign block_done = accept && (count == LAST_COUNT);
  assign sum        = acc + ACC_W'(i_Sample);
  assign avg_next   = 8'(sum >> SAMPLES_LOG2);
  assign o_Stale    = (idle == IDLE_LIMIT);

`ifdef LIGHT_FILTER_PEAK_HOLD_EN
  assign display_value = o_Peak;
`else
  assign display_value = o_Avg;
`endif

  // Accumulate samples; the block's last sample restarts the block directly.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      acc   <= '0;
      count <= '0;
    end else if (i_Clear || block_done) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      acc   <= sum;
      count <= count + 1'b1;
    end
  end

  // Publish the block average with a one-clock strobe and track its peak.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Avg    <= '0;
      o_Avg_DV <= 1'b0;
      o_Peak   <= '0;
    end else begin
      o_Avg_DV <= block_done;
      if (block_done) begin
        o_Avg <= avg_next;
      end
      if (i_Clear) begin
        o_Peak <= '0;
      end else if (block_done && (avg_next > o_Peak)) begin
        o_Peak <= avg_next;
      end
    end
  end

  // Idle timer: restarts on each accepted strobe, saturates at the limit, holds during clear.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      idle <= IDLE_LIMIT;
    end else if (i_Clear) begin
      idle <= idle;
    end else if (i_Sample_DV) begin
      idle <= '0;
    end else if (idle != IDLE_LIMIT) begin
      idle <= idle + 1'b1;
    end
  end

  // Registered digit drive: dashes while stale, otherwise the hex value.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      seg1_n <= DASH_N;
      seg2_n <= DASH_N;
    end else if (o_Stale) begin
      seg1_n <= DASH_N;
      seg2_n <= DASH_N;
    end else begin
      seg1_n <= ~hex_glyph(display_value[7:4]);
      seg2_n <= ~hex_glyph(display_value[3:0]);
    end
  end

  assign o_Segment1_A = seg1_n[0];
  assign o_Segment1_B = seg1_n[1];
  assign o_Segment1_C = seg1_n[2];
  assign o_Segment1_D = seg1_n[3];
  assign o_Segment1_E = seg1_n[4];
  assign o_Segment1_F = seg1_n[5];
  assign o_Segment1_G = seg1_n[6];
  assign o_Segment2_A = seg2_n[0];
  assign o_Segment2_B = seg2_n[1];
  assign o_Segment2_C = seg2_n[2];
  assign o_Segment2_D = seg2_n[3];
  assign o_Segment2_E = seg2_n[4];
  assign o_Segment2_F = seg2_n[5];
  assign o_Segment2_G = seg2_n[6];

endmodule
